addsub_digit_seq: RTL and testbench

Parametrised, multi-cycle, digit-serial adder/subtractor for NBITS-wide operands. It processes DIGIT bits per clock from a latched copy of the operands, LSB digit first. A start/busy/done handshake frames each operation. It is the sequential successor to the team's combinational ripple-carry generator: it trades latency for a single DIGIT-wide adder slice, and adds subtract mode and a signed-overflow flag.

---
 rtl/addsub_digit_seq.sv | 142 ++++++++++++++
 tb/tb_addsub_digit_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_digit_seq.sv
// addsub_digit_seq
//   Digit-serial adder/subtractor. Operands are latched on start and then
//   added DIGIT bits per clock, LSB digit first, through a single
//   DIGIT+1-bit adder slice. A full operation takes NDIG = NBITS/DIGIT
//   cycles in RUN, followed by one DONE cycle that pulses done.
//
//   Handshake: start is sampled only in IDLE or DONE. When sampled high,
//   sub/a/b/cin are captured in the same edge. busy is high for the NDIG
//   RUN cycles. done is high for exactly one cycle, and r/cout/ovf are
//   already valid in that cycle. start during RUN is ignored.
//
//   Ports:
//     clk, rst    clock; synchronous active-high reset
//     start       operation request
//     sub         0 = add, 1 = subtract (a - b - cin)
//     a, b        NBITS operands
//     cin         carry-in (add) / borrow-in (sub)
//     busy        digits being processed
//     done        one-cycle completion pulse
//     r           result register (holds the last result)
//     cout        carry out of bit NBITS-1 (sub: 1 = no borrow)
//     ovf         signed overflow, built only with ADDSUB_DIGIT_OVF_EN
//
//   Build option: define ADDSUB_DIGIT_OVF_EN to build the overflow capture.
//   Without it, ovf is tied to 0.
module addsub_digit_seq #(
  parameter int NBITS = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] r,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = NBITS / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;      // already inverted for subtract
  logic [NBITS-1:0] acc;      // partial result, filled one slice per cycle
  logic [NBITS-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [31:0]      base;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   sum;
  logic             last;
  logic             launch;

  // Digit slice datapath: one DIGIT+1-bit add per cycle.
  always_comb begin
    base     = 32'(cnt) * 32'(DIGIT);
    a_dig    = a_q[base +: DIGIT];
    b_dig    = b_q[base +: DIGIT];
    sum      = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    acc_next = acc;
    acc_next[base +: DIGIT] = sum[DIGIT-1:0];
    last     = (cnt == CW'(NDIG - 1));
    launch   = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      r     <= '0;
      cout  <= 1'b0;
    end else if (launch) begin
      // Subtract is a + ~b + ~cin, so fold the inversion into the latch.
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          acc   <= acc_next;
          carry <= sum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last) begin
            r     <= acc_next;
            cout  <= sum[DIGIT];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDSUB_DIGIT_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the MSB, recovered from the MSB sum bit and its operand bits.
  assign msb_cin = sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (!launch && (state == RUN) && last) begin
      ovf_q <= msb_cin ^ sum[DIGIT];
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_digit_seq.sv
module tb_addsub_digit_seq;

  localparam int NBITS = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = NBITS / DIGIT;
  localparam int W     = NBITS + 2;   // {ovf, cout, r}

`ifdef ADDSUB_DIGIT_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] r;
  logic             cout;
  logic             ovf;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  addsub_digit_seq #(.NBITS(NBITS), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .cout  (cout),
    .ovf   (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic start_op(input logic [NBITS-1:0] ta, input logic [NBITS-1:0] tb,
                          input logic tsub, input logic tcin);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [NBITS-1:0] er, input logic ec, input logic eo);
    exp_q.push_back({eo, ec, er});
  endtask

  // Called just after the start edge; returns edges until done and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) bcnt++;
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [NBITS-1:0] ta, input logic [NBITS-1:0] tb,
                        input logic tsub, input logic tcin,
                        input logic [NBITS-1:0] er, input logic ec, input logic eo);
    int cyc;
    int bcnt;
    push_exp(er, ec, eo);
    start_op(ta, tb, tsub, tcin);
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, cyc, NDIG);
    check({tag, "_busy_cycles"}, bcnt, NDIG);
    step();
    check({tag, "_done_after"}, {31'b0, done}, 0);
  endtask

  // scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_r", {16'b0, r}, {16'b0, e[NBITS-1:0]});
        check("sb_cout", {31'b0, cout}, {31'b0, e[NBITS]});
        check("sb_ovf", {31'b0, ovf}, {31'b0, e[NBITS+1]});
        check("sb_busy", {31'b0, busy}, 0);
      end
    end
  end

  initial begin
    int cyc;
    int bcnt;
    int dcnt;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_r", {16'b0, r}, 0);
    check("rst_cout", {31'b0, cout}, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    rst = 1'b0;
    step();

    // basic add / sub vectors
    run_op("add_cin",  16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_bin",  16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_EN);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, OVF_EN);

    // start re-pulsed and operands changed mid-RUN
    push_exp(16'h0120, 1'b0, 1'b0);
    start_op(16'h0100, 16'h0020, 1'b0, 1'b0);      // now after E0
    step();                                        // after E1
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
    step();                                        // after E2
    start = 1'b0;
    check("mid_busy", {31'b0, busy}, 1);
    step();                                        // after E3
    check("mid_done_e3", {31'b0, done}, 0);
    step();                                        // after E4
    check("mid_done_e4", {31'b0, done}, 1);
    step();
    check("mid_no_requeue", {31'b0, busy}, 0);

    // back-to-back: start held during DONE
    push_exp(16'h1234, 1'b0, 1'b0);
    start_op(16'h1000, 16'h0234, 1'b0, 1'b0);
    wait_done(cyc, bcnt);
    check("b2b_first_latency", cyc, NDIG);
    push_exp(16'h4000, 1'b1, 1'b0);
    a = 16'h4321; b = 16'h0321; sub = 1'b1; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_restart_busy", {31'b0, busy}, 1);
    wait_done(cyc, bcnt);
    check("b2b_second_latency", cyc, NDIG);
    step();

    // reset after the 2nd RUN edge
    start_op(16'h2222, 16'h1111, 1'b0, 1'b0);      // after E0
    step();                                        // after E1
    step();                                        // after E2
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_r", {16'b0, r}, 0);
    check("abort_cout", {31'b0, cout}, 0);
    check("abort_ovf", {31'b0, ovf}, 0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dcnt++;
      step();
    end
    check("abort_no_done", dcnt, 0);
    run_op("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    step();
    check("sb_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
